slave_port_ctrl: RTL and testbench
==================================

// Module: slave_port_ctrl
// PURPOSE
//  Serial-bus slave port controller, directly upstream of the slave BRAM memory.
//  - Deserialises a bit-serial request (mode, address, write data) into parallel form.
//  - Drives the memory's wen/ren/addr/wdata.
//  - For reads, holds ren until the memory's rvalid, then serialises rdata back onto the bus.
//  - One outstanding transaction; ready flags when a new one may start.
// PARAMETERS
//  ADDR_WIDTH  12  address bits received serially and driven on mem_addr
//  DATA_WIDTH  8   data bits per transfer (write and read)
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rstn        in   1           asynchronous, active-low reset
//  mvalid      in   1           serial bit valid from bus (qualifies swdata; smode on first bit)
//  smode       in   1           1 = write, 0 = read; sampled only on the start cycle
//  swdata      in   1           serial address/write-data bit, LSB first
//  ready       out  1           1 = idle, a new transaction may start
//  srdata      out  1           serial read-data bit, LSB first
//  srvalid     out  1           qualifies srdata
//  mem_wen     out  1           memory write enable, single-cycle pulse
//  mem_ren     out  1           memory read enable, held until mem_rvalid
//  mem_addr    out  ADDR_WIDTH  memory address, stable throughout MEMWR/MEMRD
//  mem_wdata   out  DATA_WIDTH  memory write data, stable while mem_wen=1
//  mem_rdata   in   DATA_WIDTH  memory read data
//  mem_rvalid  in   1           memory read data valid
// BEHAVIOUR
//  Reset values
//  - All outputs 0 except ready=1. State=IDLE. Counters, shift and capture registers = 0.
//  - Reset mid-transaction aborts immediately. No memory access is issued afterwards.
//  States and transitions
//  - IDLE: ready=1. mvalid=1 latches smode and shifts swdata into addr bit 0.
//    Bit counter=1, go to ADDR.
//  - ADDR: on each mvalid=1, swdata shifts into addr[cnt] and cnt increments.
//    mvalid=0 stalls; cnt and addr hold.
//    After bit ADDR_WIDTH-1: write goes to WDATA, read goes to MEMRD. cnt clears.
//  - WDATA: same shifting and stall rules into wdata[cnt].
//    After bit DATA_WIDTH-1, go to MEMWR.
//  - MEMWR: mem_wen=1 for exactly one cycle, with mem_addr/mem_wdata valid. Then IDLE.
//  - MEMRD: mem_ren=1 every cycle in this state. The memory needs >=2 ren cycles before rvalid.
//    On a cycle with mem_rvalid=1: capture mem_rdata, leave MEMRD, mem_ren=0 next cycle.
//    There is no timeout.
//  - RDOUT: srvalid=1 for exactly DATA_WIDTH consecutive cycles; srdata = captured bit 0,1,...
//    Then IDLE with srvalid=0.
//  Output timing
//  - All outputs are registered. ready=0 from the cycle after the start bit until IDLE is re-entered.
//  - mvalid is ignored in MEMWR, MEMRD and RDOUT. It is also ignored on the IDLE return cycle's predecessor.
//  - The start bit counts as address bit 0, so an ADDR_WIDTH-bit address takes ADDR_WIDTH mvalid cycles.
//  Latency
//  - Write: mem_wen asserts the cycle after the last data bit. ready=1 one cycle later.
//  - Read (with the BRAM slave): ren high 3 cycles, capture in the 3rd.
//    srvalid first high the cycle after capture.
//  Widths
//  - Bit counter is $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1) bits. Compare against WIDTH-1.
//  - No address range check; the memory truncates the address.
//  Boundaries
//  - Back-to-back: mvalid=1 on the first ready=1 cycle starts the next transaction.
//  - mem_rvalid outside MEMRD is ignored.
//  - Stalls of any length in ADDR/WDATA are legal.
// TESTING
//  1 Write addr 0x5A3 data 0xC7, mvalid continuous
//    -> exactly one mem_wen pulse with mem_addr=0x5A3, mem_wdata=0xC7; 20 bit cycles, wen on cycle 21.
//  2 Read 0x5A3 after test 1, against the BRAM slave
//    -> mem_ren high 3 cycles; srvalid 8 cycles; srdata LSB-first = 1,1,1,0,0,0,1,1.
//  3 Write 0xFFF/0x01 with mvalid dropped for 5 cycles mid-address and mid-data
//    -> correct addr/data; no early wen.
//  4 Read with mem_rvalid stub delayed 10 cycles
//    -> mem_ren held 10+ cycles, mem_addr stable, data captured only on rvalid.
//  5 rstn pulsed low mid-WDATA and again mid-RDOUT
//    -> outputs 0, ready=1, no mem_wen ever; next write completes normally.
//  6 Back-to-back write then read of 0x000, mvalid=1 on first ready cycle
//    -> second transaction starts with no lost bits; read returns written data.

Source files
------------

// File: rtl/slave_port_ctrl_if.sv
// Serial slave-port bundle: bit-serial bus side plus the parallel memory side.
interface slave_port_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  mvalid;
  logic                  smode;
  logic                  swdata;
  logic                  ready;
  logic                  srdata;
  logic                  srvalid;
  logic                  mem_wen;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  mvalid, smode, swdata, mem_rdata, mem_rvalid,
    output ready, srdata, srvalid, mem_wen, mem_ren, mem_addr, mem_wdata
  );

  modport master (
    output mvalid, smode, swdata, mem_rdata, mem_rvalid,
    input  ready, srdata, srvalid, mem_wen, mem_ren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/slave_port_ctrl.sv
// Serial-bus slave port: deserialises mode/addr/wdata, drives the BRAM,
// and serialises read data back LSB first. One transaction in flight.
module slave_port_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  slave_port_ctrl_if.slave  bus
);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, MEMRD, RDOUT} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q, srdata_q, srvalid_q, wen_q, ren_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      srdata_q  <= 1'b0;
      srvalid_q <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
    end else begin
      case (state)
        // The start bit doubles as address bit 0.
        IDLE: if (bus.mvalid) begin
          mode    <= bus.smode;
          addr[0] <= bus.swdata;
          cnt     <= CW'(1);
          ready_q <= 1'b0;
          state   <= ADDR;
        end
        ADDR: if (bus.mvalid) begin
          for (int i = 0; i < ADDR_WIDTH; i++)
            if (cnt == CW'(i)) addr[i] <= bus.swdata;
          if (cnt == CW'(ADDR_WIDTH-1)) begin
            cnt <= '0;
            if (mode) state <= WDATA;
            else begin
              state <= MEMRD;
              ren_q <= 1'b1;
            end
          end else cnt <= cnt + CW'(1);
        end
        WDATA: if (bus.mvalid) begin
          for (int i = 0; i < DATA_WIDTH; i++)
            if (cnt == CW'(i)) wdata[i] <= bus.swdata;
          if (cnt == CW'(DATA_WIDTH-1)) begin
            cnt   <= '0;
            wen_q <= 1'b1;
            state <= MEMWR;
          end else cnt <= cnt + CW'(1);
        end
        MEMWR: begin
          wen_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        // ren stays up until the memory answers; no timeout.
        MEMRD: if (bus.mem_rvalid) begin
          ren_q     <= 1'b0;
          srvalid_q <= 1'b1;
          srdata_q  <= bus.mem_rdata[0];
          rdata_q   <= bus.mem_rdata >> 1;
          cnt       <= '0;
          state     <= RDOUT;
        end
        RDOUT: begin
          if (cnt == CW'(DATA_WIDTH-1)) begin
            srvalid_q <= 1'b0;
            srdata_q  <= 1'b0;
            ready_q   <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt      <= cnt + CW'(1);
            srdata_q <= rdata_q[0];
            rdata_q  <= rdata_q >> 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.srdata    = srdata_q;
  assign bus.srvalid   = srvalid_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_ren   = ren_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
endmodule

// File: tb/tb_slave_port_ctrl.sv
// Bench for slave_port_ctrl: vector table plus reset corner sequences, BRAM model, scoreboard.
module tb_slave_port_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  slave_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  slave_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  typedef struct {
    bit          mode;
    logic [11:0] addr;
    logic [7:0]  data;
    int          stall_a;
    int          stall_d;
    int          lat;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          t0;
    int          exp_lat;
    int          ren_len;
  } txn_t;

  txn_t wr_q[$];
  txn_t rd_q[$];
  vec_t vecs[8];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: rvalid after lat consecutive ren cycles; garbage rdata otherwise
  logic [7:0] bram [4096];
  logic       rv = 1'b0;
  logic [7:0] rd = 8'h00;
  int         ren_cnt = 0;
  int         lat = 2;
  assign bus.mem_rvalid = rv;
  assign bus.mem_rdata  = rd;
  always @(posedge clk) begin
    if (bus.mem_wen) bram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_ren && ren_cnt + 1 >= lat) begin
      rv <= 1'b1;
      rd <= bram[bus.mem_addr];
    end else begin
      rv <= 1'b0;
      rd <= 8'($urandom);
    end
    ren_cnt <= bus.mem_ren ? ren_cnt + 1 : 0;
  end

  // Output monitor / scoreboard consumer
  int         ren_run = 0;
  int         sv_run = 0;
  bit         wen_prev = 1'b0;
  logic [11:0] ren_addr;
  logic [7:0]  acc;
  txn_t        me;
  always @(negedge clk) begin
    if (!rstn) begin
      ren_run  = 0;
      sv_run   = 0;
      wen_prev = 1'b0;
      acc      = '0;
    end else begin
      if (wen_prev) chk("wen_pulse_then_ready", {30'd0, bus.mem_wen, bus.ready}, 32'h1);
      if (bus.mem_wen && !wen_prev) begin
        if (wr_q.size() == 0) chk("unexpected_wen", 1, 0);
        else begin
          me = wr_q.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(me.addr));
          chk("wr_data", 32'(bus.mem_wdata), 32'(me.data));
          chk("wr_latency", cyc - me.t0, me.exp_lat);
        end
      end
      wen_prev = bus.mem_wen;

      if (bus.mem_ren) begin
        if (ren_run == 0) begin
          if (rd_q.size() == 0) chk("unexpected_ren", 1, 0);
          else chk("rd_addr", 32'(bus.mem_addr), 32'(rd_q[0].addr));
          ren_addr = bus.mem_addr;
        end else chk("ren_addr_stable", 32'(bus.mem_addr), 32'(ren_addr));
        ren_run++;
      end else if (ren_run > 0) begin
        if (rd_q.size() > 0) chk("ren_len", ren_run, rd_q[0].ren_len);
        chk("srvalid_after_capture", 32'(bus.srvalid), 1);
        ren_run = 0;
      end

      if (bus.srvalid) begin
        if (sv_run < DW) acc[sv_run] = bus.srdata;
        sv_run++;
      end else if (sv_run > 0) begin
        if (rd_q.size() == 0) chk("unexpected_srvalid", 1, 0);
        else begin
          me = rd_q.pop_front();
          chk("srvalid_len", sv_run, DW);
          chk("rd_data", 32'(acc), 32'(me.data));
        end
        sv_run = 0;
      end
    end
  end

  // Drives one transaction serially; stalls 5 cycles before bit stall_a/stall_d.
  // abort_at >= 0 stops driving before that bit (caller then resets).
  task automatic send(input bit mode, input logic [11:0] a, input logic [7:0] d,
                      input int stall_a, input int stall_d, input int abort_at, input int lat_i);
    int n, w, ns;
    logic [19:0] bits;
    txn_t e;
    n = mode ? AW + DW : AW;
    bits = {d, a};
    w = 0;
    while (!bus.ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    lat = lat_i;
    ns = ((stall_a >= 0 && stall_a < n) ? 1 : 0) + ((stall_d >= 0 && stall_d < n) ? 1 : 0);
    e.addr = a; e.data = d; e.t0 = cyc; e.exp_lat = n + 5 * ns; e.ren_len = lat_i + 1;
    if (mode) wr_q.push_back(e);
    else rd_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      if (i == stall_a || i == stall_d)
        repeat (5) begin
          bus.mvalid = 1'b0;
          bus.swdata = 1'($urandom);
          bus.smode  = 1'($urandom);
          @(negedge clk);
        end
      bus.mvalid = 1'b1;
      bus.smode  = (i == 0) ? mode : 1'($urandom);
      bus.swdata = bits[i];
      @(negedge clk);
    end
    bus.mvalid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0 || !bus.ready) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", wr_q.size() + rd_q.size(), 0);
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {7'd0, bus.ready, bus.srvalid, bus.srdata, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata},
        {7'd0, 1'b1, 4'b0, 12'h000, 8'h00});
  endtask

  initial begin
    int w;
    vecs[0] = '{1'b1, 12'h5A3, 8'hC7, -1, -1, 2};
    vecs[1] = '{1'b0, 12'h5A3, 8'hC7, -1, -1, 2};
    vecs[2] = '{1'b1, 12'hFFF, 8'h01,  5, 15, 2};
    vecs[3] = '{1'b0, 12'hFFF, 8'h01, -1, -1, 10};
    vecs[4] = '{1'b1, 12'h2B7, 8'h5E, -1, -1, 2};
    vecs[5] = '{1'b0, 12'h2B7, 8'h5E,  3, -1, 2};
    vecs[6] = '{1'b1, 12'h000, 8'hA5, -1, -1, 2};
    vecs[7] = '{1'b0, 12'h000, 8'hA5, -1, -1, 2};
    for (int i = 0; i < 4096; i++) bram[i] = 8'h00;
    bus.mvalid = 1'b0;
    bus.smode  = 1'b0;
    bus.swdata = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    #2 rstn = 1'b1;
    @(negedge clk);

    // vectors 6/7 run back-to-back: send starts on the first ready cycle
    for (int k = 0; k < 8; k++)
      send(vecs[k].mode, vecs[k].addr, vecs[k].data, vecs[k].stall_a, vecs[k].stall_d, -1, vecs[k].lat);
    drain();

    // reset mid-WDATA: write must never reach memory
    send(1'b1, 12'h3C3, 8'h77, -1, -1, 15, 2);
    #2 rstn = 1'b0;
    #1 chk_reset("reset_mid_wdata");
    bus.mvalid = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    #2 rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_write_after_abort", 32'(bram[12'h3C3]), 32'h00);

    // reset mid-RDOUT
    send(1'b0, 12'h5A3, 8'hC7, -1, -1, -1, 2);
    w = 0;
    while (!bus.srvalid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("srvalid_seen", 32'(bus.srvalid), 1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset("reset_mid_rdout");
    repeat (2) @(negedge clk);
    rd_q.delete();
    #2 rstn = 1'b1;
    @(negedge clk);

    send(1'b1, 12'h123, 8'h9C, -1, -1, -1, 2);
    send(1'b0, 12'h123, 8'h9C, -1, -1, -1, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
